adc_window_detector: RTL and testbench

- Parametrised successor of the three-sample ADC threshold detector.
- Drives an external ADC through the soc/eoc handshake and keeps the last N samples in a circular buffer with a running sum.
- Compares the sum against a runtime threshold and supports block-window and sliding-window modes.
- Sits between the ADC front-end and the event/alarm logic.

---
 rtl/adc_window_detector_pkg.sv | 23 ++
 rtl/adc_window_detector_if.sv | 24 ++
 rtl/adc_handshake.sv | 46 ++++
 rtl/adc_window_detector.sv | 135 +++++++++++++
 tb/tb_adc_window_detector.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/adc_window_detector_pkg.sv
// Shared types and constants for the ADC window detector.
// Imported by the handshake and the window datapath.
package adc_win_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT,
        EVAL
    } state_t;

    localparam logic MODE_BLOCK = 1'b0;
    localparam logic MODE_SLIDE = 1'b1;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    function automatic bit n_is_legal(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/adc_window_detector_if.sv
// ADC conversion bus: start request out, end-of-conversion and data back.
// master = detector side, slave = converter side.
interface adc_window_detector_if #(
    parameter int W = 8
) ();
    import adc_win_pkg::*;

    logic         soc;
    logic         eoc;
    logic [W-1:0] x;

    modport master (
        output soc,
        input  eoc,
        input  x
    );

    modport slave (
        input  soc,
        output eoc,
        output x
    );

endinterface

// File: rtl/adc_handshake.sv
// soc/eoc sequencing: raises soc on start, waits for eoc low then high,
// and pulses done on the edge where eoc is seen high again.
module adc_handshake
    import adc_win_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_eoc,
    output logic o_soc,
    output logic o_done
);

    state_t r_state;
    state_t w_next;
    logic   r_soc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_soc   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_soc   <= (w_next == REQ);
        end
    end

    always_comb begin
        w_next = r_state;
        o_done = 1'b0;
        unique case (r_state)
            IDLE: if (i_start) w_next = REQ;
            REQ:  if (!i_eoc) w_next = WAIT;
            WAIT: begin
                if (i_eoc) begin
                    w_next = IDLE;
                    o_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_soc = r_soc;

endmodule

// File: rtl/adc_window_detector.sv
// Window detector: circular sample buffer with running sum compared
// against a runtime threshold, in block or sliding window mode.
module adc_window_detector
    import adc_win_pkg::*;
#(
    parameter int W    = 8,
    parameter int N    = 3,
    parameter int SUMW = W + $clog2(N + 1)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_en,
    input  logic            i_mode,
    input  logic [SUMW-1:0] i_thr,
    adc_window_detector_if.master adc,
    output logic            o_out,
    output logic            o_out_valid,
    output logic [SUMW-1:0] o_sum
);

    localparam int PW = $clog2(N);
    localparam int FW = $clog2(N + 1);

    if (!n_is_legal(N)) begin : g_n_check
        $error("adc_window_detector: N must be in 2..16");
    end

    state_t r_state;
    state_t w_next;
    logic   w_start;
    logic   w_done;
    logic   w_soc;

    adc_handshake u_hs (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_eoc   (adc.eoc),
        .o_soc   (w_soc),
        .o_done  (w_done)
    );

    assign adc.soc = w_soc;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // REQ here covers the whole handshake; the sub-module splits REQ/WAIT
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_en) begin
                    w_next  = REQ;
                    w_start = 1'b1;
                end
            end
            REQ:  if (w_done) w_next = CAPT;
            CAPT: w_next = EVAL;
            EVAL: begin
                if (i_en) begin
                    w_next  = REQ;
                    w_start = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    logic [W-1:0]    r_buf [N];
    logic [PW-1:0]   r_wp;
    logic [FW-1:0]   r_fill;
    logic [SUMW-1:0] r_sum;
    logic            r_out;
    logic            r_out_valid;
    logic            r_mode_last;
    logic            r_mode_vld;

    logic            w_full;
    logic [SUMW-1:0] w_old;
    logic            w_mode_chg;

    assign w_full     = (r_fill == FW'(N));
    assign w_old      = w_full ? SUMW'(r_buf[r_wp]) : '0;
    assign w_mode_chg = r_mode_vld && (i_mode != r_mode_last);

    always_ff @(posedge i_clock) begin
        if (r_state == CAPT) r_buf[r_wp] <= adc.x;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wp        <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_mode_last <= MODE_BLOCK;
            r_mode_vld  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == CAPT) begin
                r_sum <= r_sum + SUMW'(adc.x) - w_old;
                r_wp  <= (r_wp == PW'(N - 1)) ? '0 : r_wp + PW'(1);
                if (!w_full) r_fill <= r_fill + FW'(1);
            end
            if (r_state == EVAL) begin
                r_mode_last <= i_mode;
                r_mode_vld  <= 1'b1;
                // a mode switch restarts the window without a decision
                if (w_mode_chg) begin
                    r_fill <= '0;
                    r_sum  <= '0;
                end else if (w_full) begin
                    r_out       <= (r_sum >= i_thr);
                    r_out_valid <= 1'b1;
                    if (i_mode == MODE_BLOCK) begin
                        r_fill <= '0;
                        r_sum  <= '0;
                    end
                end
            end
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;

endmodule

// File: tb/tb_adc_window_detector.sv
// Directed bench for adc_window_detector (W=8, N=3) with a
// behavioural ADC driven from the stimulus tasks.
module tb_adc_window_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [9:0] thr;
    logic       out;
    logic       out_valid;
    logic [9:0] sum;

    int n_pass  = 0;
    int n_total = 0;
    bit prev_v  = 1'b0;
    bit dbl_v   = 1'b0;

    adc_window_detector_if #(.W(8)) adc_bus ();

    adc_window_detector #(.W(8), .N(3)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_en        (en),
        .i_mode      (mode),
        .i_thr       (thr),
        .adc         (adc_bus),
        .o_out       (out),
        .o_out_valid (out_valid),
        .o_sum       (sum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && prev_v) dbl_v = 1'b1;
        prev_v = out_valid;
    end

    typedef struct {
        bit rst;
        bit mode;
        int thr;
        int hold;
        bit drop;
        int s;
        int e_soc;
        int e_sum;
        bit e_vld;
        bit e_out;
        int e_after;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, bit m, int t, int h, bit d, int s,
                                int es, int esum, bit ev, bit eo, int ea);
        vec_t v;
        v.rst = r; v.mode = m; v.thr = t; v.hold = h; v.drop = d;
        v.s = s; v.e_soc = es; v.e_sum = esum; v.e_vld = ev;
        v.e_out = eo; v.e_after = ea;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adc_bus.eoc = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // one full conversion: soc seen, eoc low, eoc high with data, evaluate
    task automatic run_vec(input vec_t v, input string tag);
        bit got;
        int cnt;
        int sum_cap;
        if (v.rst) do_reset();
        mode = v.mode;
        thr  = 10'(v.thr);
        got  = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (adc_bus.soc) got = 1'b1;
            else tick();
        end
        if (!got) chk({tag, "_soc_timeout"}, 0, 1);
        cnt = 1;
        if (adc_bus.eoc) begin
            repeat (v.hold - 1) begin
                tick();
                cnt += int'(adc_bus.soc);
            end
            adc_bus.eoc = 1'b0;
            adc_bus.x   = 8'hAA;
        end
        tick();
        cnt += int'(adc_bus.soc);
        tick();
        adc_bus.eoc = 1'b1;
        adc_bus.x   = 8'(v.s);
        tick();
        if (v.drop) adc_bus.eoc = 1'b0;
        tick();
        adc_bus.x = 8'h55;
        sum_cap = int'(sum);
        tick();
        chk({tag, "_soc_cycles"}, cnt, v.e_soc);
        chk({tag, "_sum"}, sum_cap, v.e_sum);
        chk({tag, "_valid"}, int'(out_valid), int'(v.e_vld));
        chk({tag, "_out"}, int'(out), int'(v.e_out));
        chk({tag, "_sum_after"}, int'(sum), v.e_after);
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        en = 1'b0;
        mode = 1'b0;
        thr = '0;
        adc_bus.eoc = 1'b1;
        adc_bus.x = '0;

        do_reset();
        chk("rst_soc", int'(adc_bus.soc), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        en = 1'b1;

        // block mode
        vt.push_back(mk(1, 0, 164, 5, 0,  50, 5,  50, 0, 0,  50));
        vt.push_back(mk(0, 0, 164, 1, 0,  60, 1, 110, 0, 0, 110));
        vt.push_back(mk(0, 0, 164, 1, 0,  60, 1, 170, 1, 1,   0));
        vt.push_back(mk(0, 0, 164, 1, 0,  60, 1,  60, 0, 1,  60));
        vt.push_back(mk(0, 0, 164, 1, 0,  60, 1, 120, 0, 1, 120));
        vt.push_back(mk(0, 0, 164, 1, 0,  40, 1, 160, 1, 0,   0));
        // sliding mode, with an early eoc drop before vector 9
        vt.push_back(mk(1, 1, 164, 1, 0,  50, 1,  50, 0, 0,  50));
        vt.push_back(mk(0, 1, 164, 1, 1,  60, 1, 110, 0, 0, 110));
        vt.push_back(mk(0, 1, 164, 3, 0,  60, 1, 170, 1, 1, 170));
        vt.push_back(mk(0, 1, 164, 1, 0,  10, 1, 130, 1, 0, 130));
        vt.push_back(mk(0, 1, 164, 1, 0, 100, 1, 170, 1, 1, 170));
        // full scale
        vt.push_back(mk(1, 1, 700, 1, 0, 255, 1, 255, 0, 0, 255));
        vt.push_back(mk(0, 1, 700, 1, 0, 255, 1, 510, 0, 0, 510));
        vt.push_back(mk(0, 1, 700, 1, 0, 255, 1, 765, 1, 1, 765));
        vt.push_back(mk(0, 1, 700, 1, 0,   0, 1, 510, 1, 0, 510));
        // thr=0, thr changes, then a mode switch flush
        vt.push_back(mk(1, 1,   0, 1, 0,   1, 1,   1, 0, 0,   1));
        vt.push_back(mk(0, 1,   0, 1, 0,   2, 1,   3, 0, 0,   3));
        vt.push_back(mk(0, 1,   0, 1, 0,   3, 1,   6, 1, 1,   6));
        vt.push_back(mk(0, 1,   7, 1, 0,   4, 1,   9, 1, 1,   9));
        vt.push_back(mk(0, 1,  10, 1, 0,   0, 1,   7, 1, 0,   7));
        vt.push_back(mk(0, 0,   5, 1, 0,   5, 1,   9, 0, 0,   0));
        vt.push_back(mk(0, 0,   5, 1, 0,  10, 1,  10, 0, 0,  10));
        vt.push_back(mk(0, 0,   5, 1, 0,  10, 1,  20, 0, 0,  20));
        vt.push_back(mk(0, 0,   5, 1, 0,  10, 1,  30, 1, 1,   0));

        for (int i = 0; i < vt.size(); i++)
            run_vec(vt[i], $sformatf("v%0d", i));

        // en dropped with a conversion in flight
        do_reset();
        run_vec(mk(0, 1, 100, 1, 0, 40, 1,  40, 0, 0,  40), "en0");
        run_vec(mk(0, 1, 100, 1, 0, 40, 1,  80, 0, 0,  80), "en1");
        en = 1'b0;
        run_vec(mk(0, 1, 100, 1, 0, 40, 1, 120, 1, 1, 120), "en2");
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (adc_bus.soc) seen = 1'b1;
        end
        chk("en_idle_soc", int'(seen), 0);
        chk("en_idle_sum", int'(sum), 120);
        en = 1'b1;
        run_vec(mk(0, 1, 100, 1, 0, 10, 1,  90, 1, 0,  90), "en3");

        // reset while waiting for eoc with two samples in the window
        do_reset();
        run_vec(mk(0, 0, 10, 1, 0, 5, 1,  5, 0, 0,  5), "rw0");
        run_vec(mk(0, 0, 10, 1, 0, 5, 1, 10, 0, 0, 10), "rw1");
        run_vec(mk(0, 0, 10, 1, 0, 5, 1, 15, 1, 1,  0), "rw2");
        run_vec(mk(0, 0, 10, 1, 0, 5, 1,  5, 0, 1,  5), "rw3");
        run_vec(mk(0, 0, 10, 1, 0, 5, 1, 10, 0, 1, 10), "rw4");
        adc_bus.eoc = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        adc_bus.eoc = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_soc", int'(adc_bus.soc), 0);
        chk("rw_out", int'(out), 0);
        chk("rw_sum", int'(sum), 0);
        chk("rw_valid", int'(out_valid), 0);
        run_vec(mk(0, 0, 10, 1, 0, 20, 1, 20, 0, 0, 20), "rw5");
        run_vec(mk(0, 0, 10, 1, 0, 20, 1, 40, 0, 0, 40), "rw6");
        run_vec(mk(0, 0, 10, 1, 0, 20, 1, 60, 1, 1,  0), "rw7");

        chk("valid_back_to_back", int'(dbl_v), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
